sdram_cmd_scheduler: RTL and testbench

- Single-request SDRAM command sequencer that sits between the front-end request port and the SDRAM command/address pins.
- Accepts one read/write request at a time and queries sdram_bank_tracker for an open-row hit.
- Issues the ACT/PRE/RD/WR command sequence while enforcing tRCD, tRP and per-bank tRAS.
- Drives the tracker's set/clear pulses so the tracker's open-row state stays coherent with the issued commands.

---
 rtl/sdram_cmd_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_sdram_cmd_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_scheduler.sv
// sdram_cmd_scheduler: single-request SDRAM command sequencer.
// Accepts one read/write request at a time and resolves it against an
// external open-row tracker (hit / empty bank / row miss). It then issues the
// ACT/PRE/RD/WR sequence while honouring tRCD, tRP and per-bank tRAS.
// The request, bank bitmap, timers and FSM state are all registered. cmd and
// the tracker pulses are decoded from that state in the output process. The
// decode has to be combinational because the DECIDE-cycle command depends on
// row_hit, and the tracker computes row_hit from our registered query_* in
// that same cycle.

module sdram_cmd_scheduler #(
    parameter int unsigned ROW_BITS  = 13,
    parameter int unsigned COL_BITS  = 10,
    parameter int unsigned BANK_BITS = 2,
    parameter int unsigned T_RCD     = 2,
    parameter int unsigned T_RP      = 2,
    parameter int unsigned T_RAS     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BANK_BITS-1:0] req_bank,
    input  logic [ROW_BITS-1:0]  req_row,
    input  logic [COL_BITS-1:0]  req_col,
    output logic [2:0]           cmd,
    output logic [BANK_BITS-1:0] cmd_bank,
    output logic [ROW_BITS-1:0]  cmd_addr,
    output logic                 set_active_pulse,
    output logic [BANK_BITS-1:0] set_bank,
    output logic [ROW_BITS-1:0]  set_row,
    output logic                 clear_active_pulse,
    output logic [BANK_BITS-1:0] clear_bank,
    output logic [BANK_BITS-1:0] query_bank,
    output logic [ROW_BITS-1:0]  query_row,
    input  logic                 row_hit
);

    localparam int unsigned NUM_BANKS = 2 ** BANK_BITS;
    localparam int unsigned MAX_T =
        (T_RAS > T_RCD) ? ((T_RAS > T_RP) ? T_RAS : T_RP)
                        : ((T_RCD > T_RP) ? T_RCD : T_RP);
    localparam int unsigned CNT_W = $clog2(MAX_T) + 1;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_PRE = 3'd2;
    localparam logic [2:0] CMD_RD  = 3'd3;
    localparam logic [2:0] CMD_WR  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_WAIT_PRE,
        S_WAIT_RP,
        S_WAIT_RCD
    } state_t;

    state_t               state;
    state_t               state_next;

    logic                 lat_we;
    logic [COL_BITS-1:0]  lat_col;
    logic [NUM_BANKS-1:0] bank_open;
    logic [CNT_W-1:0]     tras_cnt [NUM_BANKS];
    logic [CNT_W-1:0]     wait_cnt;

    logic                 bank_is_open;
    logic                 tras_done;
    logic                 wait_done;
    logic [2:0]           rw_cmd;

    // Decision terms for the latched request's bank
    assign bank_is_open = bank_open[query_bank];
    assign tras_done    = (tras_cnt[query_bank] == '0);
    assign wait_done    = (wait_cnt == '0);
    assign rw_cmd       = lat_we ? CMD_WR : CMD_RD;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (bank_is_open && row_hit) begin
                    state_next = S_IDLE;
                end else if (!bank_is_open) begin
                    state_next = S_WAIT_RCD;
                end else if (tras_done) begin
                    state_next = S_WAIT_RP;
                end else begin
                    state_next = S_WAIT_PRE;
                end
            end
            S_WAIT_PRE: begin
                if (tras_done) begin
                    state_next = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                if (wait_done) begin
                    state_next = S_WAIT_RCD;
                end
            end
            S_WAIT_RCD: begin
                if (wait_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: at most one command per cycle; set/clear never coincide
    always_comb begin
        req_ready          = 1'b0;
        cmd                = CMD_NOP;
        cmd_bank           = '0;
        cmd_addr           = '0;
        set_active_pulse   = 1'b0;
        set_bank           = '0;
        set_row            = '0;
        clear_active_pulse = 1'b0;
        clear_bank         = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_DECIDE: begin
                if (bank_is_open && row_hit) begin
                    cmd      = rw_cmd;
                    cmd_bank = query_bank;
                    cmd_addr = ROW_BITS'(lat_col);
                end else if (!bank_is_open) begin
                    cmd              = CMD_ACT;
                    cmd_bank         = query_bank;
                    cmd_addr         = query_row;
                    set_active_pulse = 1'b1;
                    set_bank         = query_bank;
                    set_row          = query_row;
                end else if (tras_done) begin
                    cmd                = CMD_PRE;
                    cmd_bank           = query_bank;
                    clear_active_pulse = 1'b1;
                    clear_bank         = query_bank;
                end
            end
            S_WAIT_PRE: begin
                if (tras_done) begin
                    cmd                = CMD_PRE;
                    cmd_bank           = query_bank;
                    clear_active_pulse = 1'b1;
                    clear_bank         = query_bank;
                end
            end
            S_WAIT_RP: begin
                if (wait_done) begin
                    cmd              = CMD_ACT;
                    cmd_bank         = query_bank;
                    cmd_addr         = query_row;
                    set_active_pulse = 1'b1;
                    set_bank         = query_bank;
                    set_row          = query_row;
                end
            end
            S_WAIT_RCD: begin
                if (wait_done) begin
                    cmd      = rw_cmd;
                    cmd_bank = query_bank;
                    cmd_addr = ROW_BITS'(lat_col);
                end
            end
            default: ;
        endcase
    end

    // Request latch, open-bank bitmap, per-bank tRAS and shared tRCD/tRP timers
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we     <= 1'b0;
            lat_col    <= '0;
            query_bank <= '0;
            query_row  <= '0;
            bank_open  <= '0;
            wait_cnt   <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                tras_cnt[i] <= '0;
            end
        end else begin
            if (state == S_IDLE && req_valid) begin
                lat_we     <= req_we;
                lat_col    <= req_col;
                query_bank <= req_bank;
                query_row  <= req_row;
            end

            if (set_active_pulse) begin
                bank_open[set_bank] <= 1'b1;
            end else if (clear_active_pulse) begin
                bank_open[clear_bank] <= 1'b0;
            end

            for (int i = 0; i < NUM_BANKS; i++) begin
                if (set_active_pulse && set_bank == BANK_BITS'(i)) begin
                    tras_cnt[i] <= CNT_W'(T_RAS - 1);
                end else if (tras_cnt[i] != '0) begin
                    tras_cnt[i] <= tras_cnt[i] - CNT_W'(1);
                end
            end

            if (set_active_pulse) begin
                wait_cnt <= CNT_W'(T_RCD - 1);
            end else if (clear_active_pulse) begin
                wait_cnt <= CNT_W'(T_RP - 1);
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Directed bench for sdram_cmd_scheduler with a behavioural open-row tracker.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_sdram_cmd_scheduler;

    localparam int NOP = 0;
    localparam int ACT = 1;
    localparam int PRE = 2;
    localparam int RD  = 3;
    localparam int WR  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_bank;
    logic [12:0] req_row;
    logic [9:0]  req_col;
    logic [2:0]  cmd;
    logic [1:0]  cmd_bank;
    logic [12:0] cmd_addr;
    logic        set_active_pulse;
    logic [1:0]  set_bank;
    logic [12:0] set_row;
    logic        clear_active_pulse;
    logic [1:0]  clear_bank;
    logic [1:0]  query_bank;
    logic [12:0] query_row;
    logic        row_hit;

    int n_checks = 0;
    int n_errors = 0;
    int overlap_cnt = 0;
    int rd_cnt = 0;

    // Tracker model: remembers the open row per bank
    logic [12:0] trk_row [4];
    logic [3:0]  trk_valid;

    always #5 clk = ~clk;

    sdram_cmd_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_we             (req_we),
        .req_bank           (req_bank),
        .req_row            (req_row),
        .req_col            (req_col),
        .cmd                (cmd),
        .cmd_bank           (cmd_bank),
        .cmd_addr           (cmd_addr),
        .set_active_pulse   (set_active_pulse),
        .set_bank           (set_bank),
        .set_row            (set_row),
        .clear_active_pulse (clear_active_pulse),
        .clear_bank         (clear_bank),
        .query_bank         (query_bank),
        .query_row          (query_row),
        .row_hit            (row_hit)
    );

    // Tracker state update, reset from the same source as the scheduler
    always @(posedge clk) begin
        if (rst) begin
            trk_valid <= '0;
            for (int i = 0; i < 4; i++) trk_row[i] <= '0;
        end else begin
            if (set_active_pulse) begin
                trk_valid[set_bank] <= 1'b1;
                trk_row[set_bank]   <= set_row;
            end
            if (clear_active_pulse) trk_valid[clear_bank] <= 1'b0;
        end
    end

    assign row_hit = trk_valid[query_bank] && (trk_row[query_bank] == query_row);

    // Set and clear must never coincide
    always @(negedge clk) begin
        if (!rst && set_active_pulse && clear_active_pulse) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input int c, input int b, input int a);
        check({tag, "_cmd"}, 32'(cmd), 32'(c));
        check({tag, "_bank"}, 32'(cmd_bank), 32'(b));
        check({tag, "_addr"}, 32'(cmd_addr), 32'(a));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a request for one cycle; returns in cycle 1 after acceptance
    task automatic issue(input logic we, input logic [1:0] b, input logic [12:0] r,
                         input logic [9:0] c);
        check("issue_ready", 32'(req_ready), 32'd1);
        req_we    = we;
        req_bank  = b;
        req_row   = r;
        req_col   = c;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_bank  = '0;
        req_row   = '0;
        req_col   = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst_ready", 32'(req_ready), 32'd1);
        check_cmd("rst", NOP, 0, 0);
        check("rst_set", 32'(set_active_pulse), 32'd0);
        check("rst_clear", 32'(clear_active_pulse), 32'd0);
        check("rst_qbank", 32'(query_bank), 32'd0);
        check("rst_qrow", 32'(query_row), 32'd0);

        // Empty bank: ACT at 1, RD at 3, ready at 4
        issue(1'b0, 2'd1, 13'h0A0, 10'h010);
        check_cmd("s1_act", ACT, 1, 'h0A0);
        check("s1_set", 32'(set_active_pulse), 32'd1);
        check("s1_set_bank", 32'(set_bank), 32'd1);
        check("s1_set_row", 32'(set_row), 32'h0A0);
        check("s1_ready1", 32'(req_ready), 32'd0);
        step();
        check_cmd("s1_c2", NOP, 0, 0);
        step();
        check_cmd("s1_rd", RD, 1, 'h010);
        step();
        check("s1_ready4", 32'(req_ready), 32'd1);

        // Row hit: WR at 1, no ACT/PRE
        issue(1'b1, 2'd1, 13'h0A0, 10'h020);
        check_cmd("s2_wr", WR, 1, 'h020);
        check("s2_set", 32'(set_active_pulse), 32'd0);
        check("s2_clear", 32'(clear_active_pulse), 32'd0);
        step();
        check("s2_ready", 32'(req_ready), 32'd1);

        // Miss before tRAS: open b2 row 5, then b2 row 6 right away
        issue(1'b0, 2'd2, 13'd5, 10'd7);
        check_cmd("s3_act5", ACT, 2, 5);
        step();
        step();
        check_cmd("s3_rd", RD, 2, 7);
        step();
        issue(1'b0, 2'd2, 13'd6, 10'd8);
        check_cmd("s3_wait", NOP, 0, 0);
        check("s3_ready_dec", 32'(req_ready), 32'd0);
        step();
        check_cmd("s3_pre", PRE, 2, 0);
        check("s3_clear", 32'(clear_active_pulse), 32'd1);
        check("s3_clear_bank", 32'(clear_bank), 32'd2);
        step();
        check_cmd("s3_rp", NOP, 0, 0);
        step();
        check_cmd("s3_act6", ACT, 2, 6);
        check("s3_set", 32'(set_active_pulse), 32'd1);
        step();
        check_cmd("s3_rcd", NOP, 0, 0);
        step();
        check_cmd("s3_rd2", RD, 2, 8);
        step();

        // Miss after tRAS: PRE at 1, ACT at 3, WR at 5
        issue(1'b0, 2'd0, 13'd3, 10'd1);
        check_cmd("s4_act3", ACT, 0, 3);
        step();
        step();
        check_cmd("s4_rd", RD, 0, 1);
        repeat (10) step();
        issue(1'b1, 2'd0, 13'd4, 10'd2);
        check_cmd("s4_pre", PRE, 0, 0);
        check("s4_clear", 32'(clear_active_pulse), 32'd1);
        step();
        check_cmd("s4_c2", NOP, 0, 0);
        step();
        check_cmd("s4_act4", ACT, 0, 4);
        step();
        check_cmd("s4_c4", NOP, 0, 0);
        step();
        check_cmd("s4_wr", WR, 0, 2);
        step();
        check("s4_ready", 32'(req_ready), 32'd1);

        // Bank 1 row stays open across traffic to other banks
        issue(1'b0, 2'd1, 13'h0A0, 10'h030);
        check_cmd("s4_b1_hit", RD, 1, 'h030);
        step();

        // Reset in WAIT_RCD abandons the request; bank then seen as empty
        issue(1'b0, 2'd3, 13'd9, 10'd3);
        check_cmd("s5_act", ACT, 3, 9);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_cmd("s5_rst", NOP, 0, 0);
        check("s5_ready", 32'(req_ready), 32'd1);
        check("s5_qrow", 32'(query_row), 32'd0);
        issue(1'b0, 2'd3, 13'd9, 10'd4);
        check_cmd("s5_act_again", ACT, 3, 9);
        step();
        step();
        check_cmd("s5_rd", RD, 3, 4);
        step();

        // req_valid held across three hits: RD on alternate cycles
        req_we   = 1'b0;
        req_bank = 2'd3;
        req_row  = 13'd9;
        req_col  = 10'd5;
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) begin
                check("s6_ready_idle", 32'(req_ready), 32'd1);
                check("s6_nop", 32'(cmd), 32'(NOP));
            end else begin
                check("s6_ready_dec", 32'(req_ready), 32'd0);
                check_cmd("s6_rd", RD, 3, 5);
            end
            if (cmd == 3'(RD)) rd_cnt++;
            req_valid = (i < 5);
            step();
        end
        check("s6_rd_count", 32'(rd_cnt), 32'd3);

        check("no_set_clear_overlap", 32'(overlap_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
